// File: rtl/fetch_queue_pkg.sv
// Shared fetch-stage types: the queue entry layout and the halt instruction encoding.
package Pipe_Buf_Reg_PKG;

  localparam int FETCH_PC_W  = 9;
  localparam int FETCH_INS_W = 32;
  localparam int FETCH_DEPTH = 4;

  localparam logic [31:0] HALT_INSTR = 32'h0000007F;

  typedef struct packed {
    logic [FETCH_PC_W-1:0]  pc;
    logic [FETCH_INS_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// DEPTH-entry circular buffer of {pc, instr} pairs with push, pop, clear and an occupancy count.
module fetch_fifo
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  fetch_entry_t             push_entry_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push_i && !clear_i;
    do_pop   = pop_i && !clear_i && (count_q != '0);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read out until count says the slot is live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) assert (count_q != CNT_W'(DEPTH));
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues imem addresses under a credit limit and queues returned words for decode.
// Optional FETCH_HALT_EN stops fetching after a HALT_INSTR word is queued, until redirect or reset.
module fetch_queue
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int PC_W  = FETCH_PC_W,
  parameter int INS_W = FETCH_INS_W,
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [PC_W-1:0]  redirect_pc_i,
  output logic [PC_W-1:0]  imem_addr_o,
  input  logic [INS_W-1:0] imem_rdata_i,
  output logic             id_valid_o,
  output logic [PC_W-1:0]  id_pc_o,
  output logic [INS_W-1:0] id_instr_o,
  output logic             halted_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  inflight_pc_q, inflight_pc_d;
  logic             inflight_q, inflight_d;
  logic [PC_W-1:0]  imem_addr;
  logic             fifo_clear, push, pop, credit_ok, halt_block;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     push_entry, head;

  assign credit_ok  = (int'(fifo_count) + int'(inflight_q)) < DEPTH;
  assign push_entry = '{pc: inflight_pc_q, instr: imem_rdata_i};

  // Redirect wins over everything: flush, drop the in-flight word, and fetch the target this cycle.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    imem_addr     = fetch_pc_q;
    fifo_clear    = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    if (redirect_i) begin
      fifo_clear    = 1'b1;
      imem_addr     = redirect_pc_i;
      inflight_d    = 1'b1;
      inflight_pc_d = redirect_pc_i;
      fetch_pc_d    = redirect_pc_i + PC_W'(4);
    end else begin
      push = inflight_q && !halt_block;
      pop  = (fifo_count != '0) && !stall_i;
      if (credit_ok && !halt_block) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + PC_W'(4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

`ifdef FETCH_HALT_EN
  logic halted_q, halted_d;

  always_comb begin
    halted_d = halted_q;
    if (redirect_i)
      halted_d = 1'b0;
    else if (push && (imem_rdata_i == INS_W'(HALT_INSTR)))
      halted_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) halted_q <= 1'b0;
    else       halted_q <= halted_d;
  end

  assign halt_block = halted_q;
`else
  assign halt_block = 1'b0;
`endif

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (fifo_clear),
    .push_i       (push),
    .pop_i        (pop),
    .push_entry_i (push_entry),
    .head_o       (head),
    .count_o      (fifo_count)
  );

  // Decode sees only registered queue contents, forced to a zero bubble when empty or in reset.
  assign id_valid_o  = !reset && (fifo_count != '0);
  assign id_pc_o     = id_valid_o ? head.pc : '0;
  assign id_instr_o  = id_valid_o ? head.instr : '0;
  assign imem_addr_o = reset ? '0 : imem_addr;
  assign halted_o    = !reset && halt_block;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue: streaming, stall, redirect, PC wrap, mid-run reset and halt.
module tb_fetch_queue;

  localparam int PC_W  = 9;
  localparam int INS_W = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             stall_i;
  logic             redirect_i;
  logic [PC_W-1:0]  redirect_pc_i;
  logic [PC_W-1:0]  imem_addr_o;
  logic [INS_W-1:0] imem_rdata_i;
  logic             id_valid_o;
  logic [PC_W-1:0]  id_pc_o;
  logic [INS_W-1:0] id_instr_o;
  logic             halted_o;

  int   tests_run    = 0;
  int   tests_failed = 0;
  logic halt_active  = 1'b0;

  fetch_queue #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .id_valid_o    (id_valid_o),
    .id_pc_o       (id_pc_o),
    .id_instr_o    (id_instr_o),
    .halted_o      (halted_o)
  );

  always #5 clk = ~clk;

  // Address-tagged memory contents; optionally a halt word at 0x00C.
  function automatic logic [INS_W-1:0] word(input logic [PC_W-1:0] a);
    if (halt_active && a == 9'h00C) return 32'h0000007F;
    return {16'hC0DE, 7'h00, a};
  endfunction

  always @(posedge clk) imem_rdata_i <= word(imem_addr_o);

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the bench finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic do_reset();
    reset         = 1'b1;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({id_valid_o, id_pc_o, id_instr_o, halted_o, imem_addr_o} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs got v=%b pc=%h ins=%h h=%b addr=%h expected all zero",
               id_valid_o, id_pc_o, id_instr_o, halted_o, imem_addr_o);
    end
  endtask

  task automatic test_stream();
    logic [PC_W-1:0] exp;
    do_reset();
    #1;
    tests_run++;
    if ({id_valid_o, imem_addr_o} !== {1'b0, 9'h000}) begin
      tests_failed++;
      $display("[TB] FAIL stream_cycle0 got v=%b addr=%h expected v=0 addr=000", id_valid_o, imem_addr_o);
    end
    @(negedge clk);
    tests_run++;
    if (id_valid_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stream_cycle1 got v=%b expected v=0", id_valid_o);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp = PC_W'(k * 4);
      tests_run++;
      if ({id_valid_o, id_pc_o, id_instr_o} !== {1'b1, exp, word(exp)}) begin
        tests_failed++;
        $display("[TB] FAIL stream_head k=%0d got v=%b pc=%h ins=%h expected v=1 pc=%h ins=%h",
                 k, id_valid_o, id_pc_o, id_instr_o, exp, word(exp));
      end
    end
  endtask

  task automatic test_stall();
    logic [PC_W-1:0] exp;
    do_reset();
    repeat (6) @(negedge clk);
    stall_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests_run++;
      if ({id_valid_o, id_pc_o} !== {1'b1, 9'h010}) begin
        tests_failed++;
        $display("[TB] FAIL stall_hold i=%0d got v=%b pc=%h expected v=1 pc=010", i, id_valid_o, id_pc_o);
      end
    end
    tests_run++;
    if (imem_addr_o !== 9'h020) begin
      tests_failed++;
      $display("[TB] FAIL stall_issue_stop got addr=%h expected 020", imem_addr_o);
    end
    stall_i = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp = PC_W'(9'h010 + k * 4);
      tests_run++;
      if ({id_valid_o, id_pc_o, id_instr_o} !== {1'b1, exp, word(exp)}) begin
        tests_failed++;
        $display("[TB] FAIL stall_release k=%0d got v=%b pc=%h ins=%h expected v=1 pc=%h ins=%h",
                 k, id_valid_o, id_pc_o, id_instr_o, exp, word(exp));
      end
    end
  endtask

  task automatic test_redirect();
    logic [PC_W-1:0] exp;
    do_reset();
    repeat (6) @(negedge clk);
    stall_i = 1'b1;
    repeat (5) @(negedge clk);
    redirect_i    = 1'b1;
    redirect_pc_i = 9'h100;
    #1;
    tests_run++;
    if (imem_addr_o !== 9'h100) begin
      tests_failed++;
      $display("[TB] FAIL redirect_issue got addr=%h expected 100", imem_addr_o);
    end
    @(negedge clk);
    tests_run++;
    if (id_valid_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL redirect_bubble got v=%b expected v=0", id_valid_o);
    end
    redirect_i = 1'b0;
    stall_i    = 1'b0;
    #1;
    tests_run++;
    if (imem_addr_o !== 9'h104) begin
      tests_failed++;
      $display("[TB] FAIL redirect_next_addr got addr=%h expected 104", imem_addr_o);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      exp = PC_W'(9'h100 + k * 4);
      tests_run++;
      if ({id_valid_o, id_pc_o, id_instr_o} !== {1'b1, exp, word(exp)}) begin
        tests_failed++;
        $display("[TB] FAIL redirect_target k=%0d got v=%b pc=%h ins=%h expected v=1 pc=%h ins=%h",
                 k, id_valid_o, id_pc_o, id_instr_o, exp, word(exp));
      end
    end
  endtask

  task automatic test_wrap();
    logic [PC_W-1:0] exp;
    do_reset();
    redirect_i    = 1'b1;
    redirect_pc_i = 9'h1F0;
    @(negedge clk);
    redirect_i = 1'b0;
    tests_run++;
    if (id_valid_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL wrap_bubble got v=%b expected v=0", id_valid_o);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp = PC_W'(9'h1F0 + k * 4);
      tests_run++;
      if ({id_valid_o, id_pc_o, id_instr_o} !== {1'b1, exp, word(exp)}) begin
        tests_failed++;
        $display("[TB] FAIL wrap_head k=%0d got v=%b pc=%h ins=%h expected v=1 pc=%h ins=%h",
                 k, id_valid_o, id_pc_o, id_instr_o, exp, word(exp));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (4) @(negedge clk);
    stall_i = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({id_valid_o, id_pc_o} !== {1'b1, 9'h008}) begin
      tests_failed++;
      $display("[TB] FAIL midreset_pre got v=%b pc=%h expected v=1 pc=008", id_valid_o, id_pc_o);
    end
    reset   = 1'b1;
    stall_i = 1'b0;
    #1;
    tests_run++;
    if ({id_valid_o, imem_addr_o} !== {1'b0, 9'h000}) begin
      tests_failed++;
      $display("[TB] FAIL midreset_during got v=%b addr=%h expected v=0 addr=000", id_valid_o, imem_addr_o);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if ({id_valid_o, imem_addr_o} !== {1'b0, 9'h000}) begin
      tests_failed++;
      $display("[TB] FAIL midreset_after got v=%b addr=%h expected v=0 addr=000", id_valid_o, imem_addr_o);
    end
    @(negedge clk);
    tests_run++;
    if (id_valid_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_cycle1 got v=%b expected v=0", id_valid_o);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tests_run++;
      if ({id_valid_o, id_pc_o} !== {1'b1, PC_W'(k * 4)}) begin
        tests_failed++;
        $display("[TB] FAIL midreset_refetch k=%0d got v=%b pc=%h expected v=1 pc=%h",
                 k, id_valid_o, id_pc_o, PC_W'(k * 4));
      end
    end
  endtask

  task automatic test_halt();
    logic             exp_valid, exp_halt;
    logic [PC_W-1:0]  exp_pc;
    logic [INS_W-1:0] exp_ins;
    halt_active = 1'b1;
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
`ifdef FETCH_HALT_EN
      exp_valid = (k <= 3);
      exp_halt  = (k >= 3);
`else
      exp_valid = 1'b1;
      exp_halt  = 1'b0;
`endif
      exp_pc  = exp_valid ? PC_W'(k * 4) : '0;
      exp_ins = exp_valid ? word(exp_pc) : '0;
      tests_run++;
      if ({id_valid_o, id_pc_o, id_instr_o, halted_o} !== {exp_valid, exp_pc, exp_ins, exp_halt}) begin
        tests_failed++;
        $display("[TB] FAIL halt_seq k=%0d got v=%b pc=%h ins=%h h=%b expected v=%b pc=%h ins=%h h=%b",
                 k, id_valid_o, id_pc_o, id_instr_o, halted_o, exp_valid, exp_pc, exp_ins, exp_halt);
      end
    end
    redirect_i    = 1'b1;
    redirect_pc_i = 9'h040;
    @(negedge clk);
    redirect_i = 1'b0;
    tests_run++;
    if ({id_valid_o, halted_o} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL halt_redirect_bubble got v=%b h=%b expected v=0 h=0", id_valid_o, halted_o);
    end
    @(negedge clk);
    tests_run++;
    if ({id_valid_o, id_pc_o, halted_o} !== {1'b1, 9'h040, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL halt_redirect_target got v=%b pc=%h h=%b expected v=1 pc=040 h=0",
               id_valid_o, id_pc_o, halted_o);
    end
    halt_active = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
